// File: rtl/alu64_ripple.sv
// Ripple-carry integer ALU (AND/OR/ADD/SUB/SLT/NOR) built from per-bit slices,
// with combinational outputs plus a registered copy for pipelined consumers.
module alu64_ripple #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Operation,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             Zero,
  output logic [WIDTH-1:0] Result_r,
  output logic             Overflow_r,
  output logic             Zero_r
);

  logic             w_ainv;
  logic             w_binv;
  logic [1:0]       w_sel;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_cin_msb;
  logic             w_ovf_raw;
  logic             w_set;
  logic [WIDTH-1:0] w_result;

  logic [WIDTH-1:0] r_result;
  logic             r_overflow;
  logic             r_zero;

  assign w_ainv = Operation[3];
  assign w_binv = Operation[2];
  assign w_sel  = Operation[1:0];
  assign w_a    = A ^ {WIDTH{w_ainv}};
  assign w_b    = B ^ {WIDTH{w_binv}};

  // Carry ripples through a single variable so the chain is evaluated in bit order.
  always_comb begin
    w_sum     = '0;
    w_carry   = w_binv;
    w_cin_msb = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) w_cin_msb = w_carry;
      w_sum[i] = w_a[i] ^ w_b[i] ^ w_carry;
      w_carry  = (w_a[i] & w_b[i]) | (w_a[i] & w_carry) | (w_b[i] & w_carry);
    end
  end

  // MSB slice: overflow from the carries around it, Set corrected for overflow.
  assign w_ovf_raw = w_cin_msb ^ w_carry;
  assign w_set     = w_sum[WIDTH-1] ^ w_ovf_raw;

  always_comb begin
    w_result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (w_sel)
        2'b00:   w_result[i] = w_a[i] & w_b[i];
        2'b01:   w_result[i] = w_a[i] | w_b[i];
        2'b10:   w_result[i] = w_sum[i];
        default: w_result[i] = (i == 0) ? w_set : 1'b0;
      endcase
    end
  end

  assign Result   = w_result;
  assign Overflow = (w_sel == 2'b10) ? w_ovf_raw : 1'b0;
  assign Zero     = ~|w_result;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      r_result   <= Result;
      r_overflow <= Overflow;
      r_zero     <= Zero;
    end
  end

  assign Result_r   = r_result;
  assign Overflow_r = r_overflow;
  assign Zero_r     = r_zero;

endmodule

// File: tb/tb_alu64_ripple.sv
// Directed bench for alu64_ripple: hand-computed vectors for every operation,
// overflow/SLT corner cases, and the registered outputs around reset.
module tb_alu64_ripple;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   Operation;
  logic [W-1:0] Result;
  logic         Overflow;
  logic         Zero;
  logic [W-1:0] Result_r;
  logic         Overflow_r;
  logic         Zero_r;

  int total = 0;
  int bad   = 0;

  alu64_ripple #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .Operation  (Operation),
    .Result     (Result),
    .Overflow   (Overflow),
    .Zero       (Zero),
    .Result_r   (Result_r),
    .Overflow_r (Overflow_r),
    .Zero_r     (Zero_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    A = a;
    B = b;
    Operation = op;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    apply(64'd123, 64'd4, 4'b0010);

    // Reset held across an edge; combinational path stays live meanwhile.
    @(posedge clk); #1;
    check("rst_result_r",   Result_r,          64'd0);
    check("rst_zero_r",     {63'd0, Zero_r},     64'd1);
    check("rst_overflow_r", {63'd0, Overflow_r}, 64'd0);
    check("rst_comb_live",  Result,            64'd127);

    check("add_result", Result,            64'd127);
    check("add_ovf",    {63'd0, Overflow}, 64'd0);
    check("add_zero",   {63'd0, Zero},     64'd0);

    apply(64'd254, 64'd254, 4'b0110);
    check("sub_eq_result", Result,            64'd0);
    check("sub_eq_zero",   {63'd0, Zero},     64'd1);
    check("sub_eq_ovf",    {63'd0, Overflow}, 64'd0);

    apply(64'd20, 64'd111, 4'b0110);
    check("sub_neg", Result, 64'hFFFF_FFFF_FFFF_FFA5);

    apply(64'hFFFF_FFFF_FFFF_FFFB, 64'd12, 4'b0010);
    check("add_neg_pos", Result, 64'd7);

    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    check("add_wrap_result", Result,            64'd0);
    check("add_wrap_zero",   {63'd0, Zero},     64'd1);
    check("add_wrap_ovf",    {63'd0, Overflow}, 64'd0);

    apply(64'd10, 64'd12, 4'b0000);
    check("and", Result, 64'd8);
    apply(64'd10, 64'd12, 4'b0001);
    check("or", Result, 64'd14);
    apply(64'd10, 64'd12, 4'b1100);
    check("nor", Result, 64'hFFFF_FFFF_FFFF_FFF1);

    apply(64'd123, 64'd10242, 4'b0111);
    check("slt_lt",      Result,        64'd1);
    check("slt_lt_zero", {63'd0, Zero}, 64'd0);
    apply(64'h8000_0000_0000_0000, 64'd1, 4'b0111);
    check("slt_ovf",     Result,            64'd1);
    check("slt_ovf_flag", {63'd0, Overflow}, 64'd0);
    apply(64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 4'b0111);
    check("slt_ge",      Result,        64'd0);
    check("slt_ge_zero", {63'd0, Zero}, 64'd1);

    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    check("add_ovf_result", Result,            64'h8000_0000_0000_0000);
    check("add_ovf_flag",   {63'd0, Overflow}, 64'd1);
    apply(64'h8000_0000_0000_0000, 64'd1, 4'b0110);
    check("sub_ovf_result", Result,            64'h7FFF_FFFF_FFFF_FFFF);
    check("sub_ovf_flag",   {63'd0, Overflow}, 64'd1);

    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000);
    check("and_ovf_masked_a", {63'd0, Overflow}, 64'd0);
    check("and_ovf_result_a", Result,            64'd1);
    apply(64'h8000_0000_0000_0000, 64'd1, 4'b0000);
    check("and_ovf_masked_b", {63'd0, Overflow}, 64'd0);
    check("and_ovf_zero_b",   {63'd0, Zero},     64'd1);

    // Release reset and capture T1 on the next edge.
    @(negedge clk);
    reset = 1'b1;
    apply(64'd123, 64'd4, 4'b0010);
    @(posedge clk); #1;
    check("reg_result_r",   Result_r,            64'd127);
    check("reg_zero_r",     {63'd0, Zero_r},     64'd0);
    check("reg_overflow_r", {63'd0, Overflow_r}, 64'd0);

    @(negedge clk);
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    @(posedge clk); #1;
    check("reg_ovf_result_r", Result_r,            64'h8000_0000_0000_0000);
    check("reg_ovf_flag_r",   {63'd0, Overflow_r}, 64'd1);

    @(negedge clk);
    apply(64'd254, 64'd254, 4'b0110);
    @(posedge clk); #1;
    check("reg_zero_set_r", {63'd0, Zero_r}, 64'd1);

    @(negedge clk);
    reset = 1'b0;
    apply(64'd123, 64'd4, 4'b0010);
    @(posedge clk); #1;
    check("rst2_result_r", Result_r,        64'd0);
    check("rst2_zero_r",   {63'd0, Zero_r}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
